// File: rtl/vdac_sar_ctrl_pkg.sv
// Shared types and constants for the SAR controller driving the temperature-sensor vdac.
package vdac_sar_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int SYNC_DEPTH = 2;

    // Mid-scale code: MSB set, all lower bits clear; callers truncate to their width.
    function automatic logic [31:0] mid_scale(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/vdac_sar_ctrl_cmp_sync.sv
// Multi-flop synchronizer for asynchronous analog-comparator outputs, reset to 0.
module cmp_sync #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/vdac_sar_ctrl.sv
// Successive-approximation controller: binary-searches the vdac code against the
// synchronized comparator, one bit per settle+compare step.
module vdac_sar_ctrl
    import vdac_sar_ctrl_pkg::*;
#(
    parameter int BITWIDTH      = 6,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic                i_start,
    input  logic                i_continuous,
    input  logic                i_cmp,
    output logic [BITWIDTH-1:0] o_dac_data,
    output logic                o_dac_en,
    output logic                o_busy,
    output logic                o_done,
    output logic [BITWIDTH-1:0] o_result
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int KW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
    localparam logic [CW-1:0]       CNT_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [KW-1:0]       K_MSB     = KW'(BITWIDTH - 1);
    localparam logic [BITWIDTH-1:0] MID_SCALE = BITWIDTH'(mid_scale(BITWIDTH));

    state_t              r_state, w_state_nxt;
    logic [BITWIDTH-1:0] r_code, w_code_nxt;
    logic [BITWIDTH-1:0] r_result, w_result_nxt;
    logic [KW-1:0]       r_k, w_k_nxt, w_k_dec;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic                w_cmp_s;
    logic                w_restart;

    cmp_sync #(
        .DEPTH (SYNC_DEPTH)
    ) u_cmp_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_cmp),
        .o_q     (w_cmp_s)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_code   <= '0;
            r_result <= '0;
            r_k      <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_code   <= w_code_nxt;
            r_result <= w_result_nxt;
            r_k      <= w_k_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign w_restart = i_enable && i_continuous;
    assign w_k_dec   = r_k - 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_code_nxt   = r_code;
        w_result_nxt = r_result;
        w_k_nxt      = r_k;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && i_start) begin
                    w_code_nxt  = MID_SCALE;
                    w_k_nxt     = K_MSB;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!i_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_COMPARE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_COMPARE: begin
                // An abort here beats the DONE transition, so the result stays untouched.
                if (!i_enable) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_code_nxt[r_k] = w_cmp_s;
                    if (r_k != '0) begin
                        w_code_nxt[w_k_dec] = 1'b1;
                        w_k_nxt             = w_k_dec;
                        w_cnt_nxt           = '0;
                        w_state_nxt         = ST_SETTLE;
                    end else begin
                        w_result_nxt = w_code_nxt;
                        w_state_nxt  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (w_restart) begin
                    w_code_nxt  = MID_SCALE;
                    w_k_nxt     = K_MSB;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_dac_data = r_code;
    assign o_result   = r_result;
    assign o_dac_en   = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_DONE);
    assign o_busy     = (r_state == ST_SETTLE) || (r_state == ST_COMPARE) ||
                        ((r_state == ST_DONE) && w_restart);

endmodule

// File: tb/tb_vdac_sar_ctrl.sv
// Self-checking bench for vdac_sar_ctrl with an ideal comparator and a binary-search model.
module tb_vdac_sar_ctrl;

    localparam int BW  = 6;
    localparam int SC  = 3;
    localparam int LAT = BW * (SC + 1) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic          cont = 1'b0;
    logic          cmp;
    logic [BW-1:0] dac;
    logic [BW-1:0] result;
    logic          dac_en;
    logic          busy;
    logic          done;
    int            tgt = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    // Ideal comparator: high when the sensed level is at or above the DAC output.
    assign cmp = (tgt >= int'(dac));

    vdac_sar_ctrl #(
        .BITWIDTH      (BW),
        .SETTLE_CYCLES (SC)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (en),
        .i_start      (start),
        .i_continuous (cont),
        .i_cmp        (cmp),
        .o_dac_data   (dac),
        .o_dac_en     (dac_en),
        .o_busy       (busy),
        .o_done       (done),
        .o_result     (result)
    );

    // Binary search over the code space: trial values in order and the final code.
    task automatic sar_model(input int t, output int trial[BW], output int res);
        int code = 0;
        for (int i = 0; i < BW; i++) begin
            int tr;
            tr = code | (1 << (BW - 1 - i));
            trial[i] = tr;
            if (t >= tr) code = tr;
        end
        res = code;
    endtask

    // Starts a conversion from a negedge in IDLE; returns at the negedge of the DONE cycle.
    task automatic run_conv(input int t, output int done_c, output int res, output int codes[BW]);
        tgt    = t;
        start  = 1'b1;
        done_c = -1;
        res    = -1;
        for (int i = 0; i < BW; i++) codes[i] = -1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (((c - 1) % (SC + 1)) == 0 && ((c - 1) / (SC + 1)) < BW)
                codes[(c - 1) / (SC + 1)] = int'(dac);
            if (done) begin
                done_c = c;
                res    = int'(result);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++; if (dac !== '0) $display("FAIL reset_dac got=%0d exp=0", dac); else n_pass++;
        n_checks++; if (result !== '0) $display("FAIL reset_result got=%0d exp=0", result); else n_pass++;
        n_checks++; if (dac_en !== 1'b0) $display("FAIL reset_dac_en got=%b exp=0", dac_en); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_accuracy();
        int trial[BW];
        int codes[BW];
        int exp_res, done_c, res;
        sar_model(37, trial, exp_res);
        run_conv(37, done_c, res, codes);
        n_checks++; if (done_c != LAT) $display("FAIL acc_latency got=%0d exp=%0d", done_c, LAT); else n_pass++;
        n_checks++; if (res != exp_res) $display("FAIL acc_result got=%0d exp=%0d", res, exp_res); else n_pass++;
        for (int i = 0; i < BW; i++) begin
            n_checks++;
            if (codes[i] != trial[i]) $display("FAIL acc_code%0d got=%0d exp=%0d", i, codes[i], trial[i]);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL acc_idle_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (dac_en !== 1'b0) $display("FAIL acc_idle_en got=%b exp=0", dac_en); else n_pass++;
        n_checks++; if (int'(dac) != exp_res) $display("FAIL acc_idle_dac got=%0d exp=%0d", dac, exp_res); else n_pass++;
    endtask

    task automatic test_targets(input int t);
        int trial[BW];
        int codes[BW];
        int exp_res, done_c, res;
        sar_model(t, trial, exp_res);
        run_conv(t, done_c, res, codes);
        n_checks++; if (res != exp_res) $display("FAIL conv_result tgt=%0d got=%0d exp=%0d", t, res, exp_res); else n_pass++;
        n_checks++; if (done_c != LAT) $display("FAIL conv_latency tgt=%0d got=%0d exp=%0d", t, done_c, LAT); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int trial[BW];
        int exp_res, n_done, first_c, res;
        sar_model(45, trial, exp_res);
        tgt = 45; start = 1'b1; n_done = 0; first_c = -1; res = -1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (done) begin
                n_done++;
                if (first_c < 0) begin first_c = c; res = int'(result); end
            end
            start = (c == 10);
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++; if (n_done != 1) $display("FAIL busy_start_ndone got=%0d exp=1", n_done); else n_pass++;
        n_checks++; if (first_c != LAT) $display("FAIL busy_start_latency got=%0d exp=%0d", first_c, LAT); else n_pass++;
        n_checks++; if (res != exp_res) $display("FAIL busy_start_result got=%0d exp=%0d", res, exp_res); else n_pass++;
    endtask

    task automatic test_abort();
        logic [BW-1:0] prior;
        int n_done;
        prior = result;
        tgt = int'(prior ^ 6'h15); start = 1'b1; n_done = 0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (done) n_done++;
            if (c == 13) begin
                n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else n_pass++;
                n_checks++; if (dac_en !== 1'b0) $display("FAIL abort_en got=%b exp=0", dac_en); else n_pass++;
                n_checks++; if (result !== prior) $display("FAIL abort_result got=%0d exp=%0d", result, prior); else n_pass++;
            end
            if (c == 12) en = 1'b0;
            @(negedge clk);
        end
        n_checks++; if (n_done != 0) $display("FAIL abort_ndone got=%0d exp=0", n_done); else n_pass++;
        n_checks++; if (result !== prior) $display("FAIL abort_hold got=%0d exp=%0d", result, prior); else n_pass++;
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_continuous();
        int trial[BW];
        int exp1, exp2, c1, c2, r1, r2, fell;
        sar_model(20, trial, exp1);
        sar_model(50, trial, exp2);
        c1 = -1; c2 = -1; r1 = -1; r2 = -1; fell = 0;
        cont = 1'b1; tgt = 20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (done && c1 >= 0) begin
                c2 = c; r2 = int'(result);
                break;
            end
            if (busy !== 1'b1) fell++;
            if (done) begin
                c1 = c; r1 = int'(result);
                tgt = 50;
            end
            if (c1 >= 0 && c == c1 + 10) cont = 1'b0;
            @(negedge clk);
        end
        n_checks++; if (c1 != LAT) $display("FAIL cont_first_latency got=%0d exp=%0d", c1, LAT); else n_pass++;
        n_checks++; if (r1 != exp1) $display("FAIL cont_first_result got=%0d exp=%0d", r1, exp1); else n_pass++;
        n_checks++; if (c2 - c1 != LAT) $display("FAIL cont_period got=%0d exp=%0d", c2 - c1, LAT); else n_pass++;
        n_checks++; if (r2 != exp2) $display("FAIL cont_second_result got=%0d exp=%0d", r2, exp2); else n_pass++;
        n_checks++; if (fell != 0) $display("FAIL cont_busy_drops got=%0d exp=0", fell); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL cont_stop_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (dac_en !== 1'b0) $display("FAIL cont_stop_en got=%b exp=0", dac_en); else n_pass++;
    endtask

    task automatic test_reset_mid();
        tgt = 13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 7; c++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (dac !== '0) $display("FAIL rstmid_dac got=%0d exp=0", dac); else n_pass++;
        n_checks++; if (result !== '0) $display("FAIL rstmid_result got=%0d exp=0", result); else n_pass++;
        n_checks++; if (dac_en !== 1'b0) $display("FAIL rstmid_en got=%b exp=0", dac_en); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rstmid_done got=%b exp=0", done); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_targets(13);
    endtask

    initial begin
        test_reset();
        test_accuracy();
        test_targets(0);
        test_targets(63);
        test_targets(32);
        for (int i = 0; i < 6; i++) test_targets(int'($urandom_range(0, 63)));
        test_start_while_busy();
        test_abort();
        test_continuous();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
